// File: rtl/lpc_record_packer.sv
// lpc_record_packer: captures decoded LPC transactions into a small record
// FIFO and streams each record out as a fixed-length byte sequence over a
// valid/ready handshake. Records that arrive while the FIFO is full are
// dropped and counted (saturating at 255).
// Optional build macro LPC_PACKER_CHECKSUM_EN appends an XOR checksum byte
// (b9 = b0 ^ ... ^ b8), making each record 10 bytes instead of 9.
module lpc_record_packer #(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          lpc_clock,
    input  logic          lpc_reset,
    input  logic [3:0]    in_cyctype_dir,
    input  logic [31:0]   in_addr,
    input  logic [31:0]   in_data,
    input  logic [3:0]    in_data_size,
    input  logic          in_valid,
    output logic [7:0]    out_byte,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] fifo_level,
    output logic [7:0]    overflow_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int RW = 72;
`ifdef LPC_PACKER_CHECKSUM_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int SW = NB * 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [RW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    ovf_q, ovf_d;
    state_t        state_q, state_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [3:0]    idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          full, empty, push, accept;
    logic          pop;
    logic [RW-1:0] head;
    logic [SW-1:0] load_img;

    // Full/empty come from registered state only, so a same-edge pop never
    // makes room for a write arriving at that edge.
    assign full   = (level_q == LW'(DEPTH));
    assign empty  = (level_q == '0);
    assign push   = in_valid && !full;
    assign accept = valid_q && out_ready;
    assign head   = mem_q[rd_ptr_q];

`ifdef LPC_PACKER_CHECKSUM_EN
    logic [7:0] csum;

    // XOR of the nine record bytes, appended as the final stream byte.
    always_comb begin
        csum = '0;
        for (int i = 0; i < RW / 8; i++) begin
            csum = csum ^ head[8*i +: 8];
        end
    end

    assign load_img = {head, csum};
`else
    assign load_img = head;
`endif

    // Next-state logic: FIFO pointers, occupancy, drop counter and sender FSM.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    shift_d = load_img;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    shift_d = {shift_q[SW-9:0], 8'h00};
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == 4'(NB - 1)) begin
                        pop     = 1'b1;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (in_valid && full && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    // State registers; reset abandons any record in flight and empties the FIFO.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
        end
    end

    // Record storage; contents need no reset because the pointers gate reads.
    always_ff @(posedge lpc_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_cyctype_dir, in_data_size, in_addr, in_data};
        end
    end

    assign out_byte       = shift_q[SW-1 -: 8];
    assign out_valid      = valid_q;
    assign fifo_level     = level_q;
    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_lpc_record_packer.sv
// Testbench for lpc_record_packer: directed scenarios plus a randomized run,
// all checked against a queue-based model of records and expected bytes.
module tb_lpc_record_packer;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef LPC_PACKER_CHECKSUM_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam logic [7:0] EXP1 [10] = '{8'h01, 8'h00, 8'h00, 8'h7F, 8'hE5,
                                         8'h00, 8'h00, 8'h00, 8'h6C, 8'hF7};

    logic          lpc_clock = 1'b0;
    logic          lpc_reset = 1'b0;
    logic [3:0]    in_cyctype_dir = '0;
    logic [31:0]   in_addr = '0;
    logic [31:0]   in_data = '0;
    logic [3:0]    in_data_size = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [LW-1:0] fifo_level;
    logic [7:0]    overflow_count;

    lpc_record_packer #(.DEPTH(DEPTH)) dut (
        .lpc_clock      (lpc_clock),
        .lpc_reset      (lpc_reset),
        .in_cyctype_dir (in_cyctype_dir),
        .in_addr        (in_addr),
        .in_data        (in_data),
        .in_data_size   (in_data_size),
        .in_valid       (in_valid),
        .out_byte       (out_byte),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count)
    );

    always #5 lpc_clock = ~lpc_clock;

    int vectors = 0;
    int miscompares = 0;

    // Model: queued records, position within the head record, drop count.
    logic [71:0] m_q [$];
    int          m_idx = 0;
    bit          m_sending = 1'b0;
    int          m_ovf = 0;
    logic [7:0]  got_bytes [$];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte i of a record: 0..8 are the record bytes MSB first, 9 is their XOR.
    function automatic logic [7:0] rec_byte(input logic [71:0] r, input int i);
        logic [71:0] t;
        logic [7:0]  x;
        if (i < 9) begin
            t = r >> (8 * (8 - i));
            return t[7:0];
        end
        x = '0;
        for (int k = 0; k < 9; k++) begin
            t = r >> (8 * k);
            x = x ^ t[7:0];
        end
        return x;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_idx = 0;
        m_sending = 1'b0;
        m_ovf = 0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit iv, input logic [3:0] ct, input logic [31:0] a,
                        input logic [31:0] dat, input logic [3:0] sz, input bit rdy);
        bit full_m, start_m, acc_m;
        in_valid = iv;
        in_cyctype_dir = ct;
        in_addr = a;
        in_data = dat;
        in_data_size = sz;
        out_ready = rdy;
        check_value("out_valid", out_valid, m_sending);
        if (m_sending) check_value("out_byte", out_byte, rec_byte(m_q[0], m_idx));
        check_value("fifo_level", fifo_level, m_q.size());
        check_value("overflow_count", overflow_count, m_ovf);
        full_m  = (m_q.size() == DEPTH);
        start_m = !m_sending && (m_q.size() > 0);
        acc_m   = m_sending && rdy;
        if (acc_m) begin
            got_bytes.push_back(out_byte);
            m_idx++;
            if (m_idx == NB) begin
                void'(m_q.pop_front());
                m_sending = 1'b0;
                m_idx = 0;
            end
        end
        if (start_m) begin
            m_sending = 1'b1;
            m_idx = 0;
        end
        if (iv) begin
            if (full_m) begin
                if (m_ovf < 255) m_ovf++;
            end else begin
                m_q.push_back({ct, sz, a, dat});
            end
        end
        @(posedge lpc_clock);
        @(negedge lpc_clock);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, rdy);
    endtask

    task automatic check_rec1(input string tag);
        check_value({tag, "_len"}, got_bytes.size(), NB);
        for (int k = 0; k < NB && k < got_bytes.size(); k++)
            check_value({tag, "_byte"}, got_bytes[k], EXP1[k]);
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(negedge lpc_clock);
        check_value("rst_valid", out_valid, 0);
        check_value("rst_byte", out_byte, 0);
        check_value("rst_level", fifo_level, 0);
        check_value("rst_ovf", overflow_count, 0);
        lpc_reset = 1'b1;
        model_clear();
        idle(2, 1'b1);

        // Single I/O read with latency check
        got_bytes.delete();
        step(1'b1, 4'h0, 32'h0000_7fe5, 32'h0000_006c, 4'h1, 1'b1);
        check_value("lat_e", out_valid, 0);
        idle(1, 1'b1);
        check_value("lat_e1_valid", out_valid, 1);
        check_value("lat_e1_b0", out_byte, 8'h01);
        idle(NB + 3, 1'b1);
        check_rec1("single");

        // Backpressure pattern 1,0,0,1,0,0,...
        got_bytes.delete();
        step(1'b1, 4'h0, 32'h0000_7fe5, 32'h0000_006c, 4'h1, 1'b1);
        for (int c = 0; c < 3 * NB + 6; c++) step(1'b0, 4'h0, 0, 0, 4'h0, (c % 3) == 0);
        check_rec1("bp");

        // Overflow: 10 strobes into a stalled FIFO
        got_bytes.delete();
        for (int i = 0; i < 10; i++) step(1'b1, 4'h2, 32'h100 + i, 32'hA000 + i, 4'h1, 1'b0);
        check_value("ovf_level", fifo_level, 8);
        check_value("ovf_count", overflow_count, 2);

        // Saturation: 300 more strobes while full
        for (int i = 0; i < 300; i++) step(1'b1, 4'h3, 32'hDEAD_0000 + i, 32'h5, 4'h4, 1'b0);
        check_value("sat_count", overflow_count, 255);
        idle(8 * (NB + 1) + 5, 1'b1);
        check_value("drain_len", got_bytes.size(), 8 * NB);
        for (int r = 0; r < 8 && (r * NB + 4) < got_bytes.size(); r++)
            check_value("drain_order", got_bytes[r * NB + 4], 8'(r));
        check_value("drain_level", fifo_level, 0);

        // Reset in the middle of a record
        for (int i = 0; i < 3; i++) step(1'b1, 4'h1, 32'h200 + i, 32'h1234_5678, 4'h2, 1'b0);
        for (int k = 0; k < 20 && !(m_sending && m_idx == 4); k++) idle(1, 1'b1);
        check_value("mid_level", fifo_level, 3);
        lpc_reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check_value("mid_rst_valid", out_valid, 0);
        check_value("mid_rst_level", fifo_level, 0);
        check_value("mid_rst_ovf", overflow_count, 0);
        model_clear();
        @(negedge lpc_clock);
        @(negedge lpc_clock);
        lpc_reset = 1'b1;
        got_bytes.delete();
        step(1'b1, 4'h0, 32'h0000_7fe5, 32'h0000_006c, 4'h1, 1'b1);
        idle(NB + 3, 1'b1);
        check_rec1("post_rst");

        // Back-to-back strobes
        got_bytes.delete();
        for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 32'h80 + i, 32'h0, 4'h1, 1'b1);
        idle(3 * (NB + 1) + 4, 1'b1);
        check_value("b2b_len", got_bytes.size(), 3 * NB);
        for (int r = 0; r < 3 && (r * NB + 4) < got_bytes.size(); r++)
            check_value("b2b_order", got_bytes[r * NB + 4], 8'h80 + 8'(r));

        // Randomized traffic
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 3) == 0, 4'($urandom), $urandom, $urandom,
                 4'($urandom), $urandom_range(0, 1) == 1);
        idle(DEPTH * (NB + 1) + 10, 1'b1);
        check_value("final_level", fifo_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lpc_record_packer.md
Name: lpc_record_packer

Overview:
- Sits directly downstream of the lpc decoder.
- Captures each decoded transaction (cycle type/dir, addr, data, size) on the decoder's one-cycle out_clock_enable strobe.
- Buffers transactions in a small record FIFO and serializes each one into a fixed-length byte stream with a valid/ready handshake, feeding the UART/host transport.
- Counts transactions lost to FIFO overflow.

Parameters:
- DEPTH, 8, record FIFO depth in records; power of two, >= 2.
- LW, $clog2(DEPTH)+1, width of fifo_level (derived, do not override).

Ports:
- lpc_clock  in  1  sole clock; all state changes on rising edge.
- lpc_reset  in  1  asynchronous, active-low reset.
- in_cyctype_dir  in  4  decoder out_cyctype_dir.
- in_addr  in  32  decoder out_addr.
- in_data  in  32  decoder out_data.
- in_data_size  in  4  decoder out_data_size.
- in_valid  in  1  decoder out_clock_enable; single-cycle strobe per transaction.
- out_byte  out  8  current stream byte.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  sink accepts out_byte when out_valid && out_ready at rising edge.
- fifo_level  out  LW  records held, including the record being sent.
- overflow_count  out  8  dropped records, saturating.

Behaviour:
- Reset (lpc_reset low, asynchronous):
  - out_valid=0, out_byte=0, fifo_level=0, overflow_count=0.
  - FIFO emptied, FSM to IDLE.
  - Takes effect immediately, including mid-record. No partial record resumes after reset.
- Record format, 9 bytes, fixed order:
  - b0 = {in_cyctype_dir, in_data_size}
  - b1..b4 = in_addr[31:24], [23:16], [15:8], [7:0]
  - b5..b8 = in_data[31:24], [23:16], [15:8], [7:0]
  - All 32 bits are always sent regardless of data_size; unused bits are sent as captured.
- Capture:
  - in_valid high at edge E with FIFO not full writes one record.
  - Full is evaluated from registered state before any same-edge pop. in_valid on a full FIFO is dropped even if the last byte is accepted at that same edge.
  - A drop increments overflow_count, saturating at 255.
- FSM states IDLE, SEND:
  - IDLE: if FIFO non-empty at edge, load head record into shift register, byte index=0, out_valid=1; go SEND.
  - SEND: out_byte = record byte[index]. On out_valid && out_ready, index++.
  - When the last byte is accepted: pop FIFO (fifo_level decrements at that edge), out_valid=0, return to IDLE.
  - This gives one idle cycle between consecutive records.
- Latency: in_valid sampled at edge E into an empty, idle block gives out_valid=1 after edge E+1 with b0 on out_byte.
- Handshake: out_byte and out_valid hold stable while out_valid && !out_ready. out_valid never drops mid-record except on reset.
- Simultaneous write and pop on a non-full FIFO: both occur; fifo_level is unchanged.
- FIFO pointers wrap modulo DEPTH. fifo_level == DEPTH means full; 0 means empty.

Optional Feature:
- Macro LPC_PACKER_CHECKSUM_EN.
- Defined: record is 10 bytes. b9 = XOR of b0..b8. Pop and return to IDLE happen on acceptance of b9.
- Undefined: record is 9 bytes; no checksum logic.
- All other behaviour is identical in both builds.

Test Plan:
- Single I/O read: in_valid with ct_dir=0, addr=0x7fe5, data=0x6c, size=1; out_ready=1.
  -> out_valid rises after edge E+1. Stream is 01 00 00 7F E5 00 00 00 6C, plus F7 with checksum.
  -> fifo_level ends at 0; overflow_count=0.
- Backpressure: same record, out_ready toggling 1,0,0,1,...
  -> each byte held stable while stalled; exact same byte sequence; no duplicates or skips.
- Overflow: DEPTH=8, out_ready=0, 10 in_valid strobes.
  -> fifo_level=8, overflow_count=2. Releasing out_ready streams exactly the first 8 records in order.
- Saturation: out_ready=0, FIFO full, 300 further strobes.
  -> overflow_count=255, no wrap.
- Reset mid-record: assert lpc_reset low after b3 is accepted with 3 records queued.
  -> out_valid=0 immediately, fifo_level=0, overflow_count=0. A new record after release streams from b0.
- Back-to-back: strobes on consecutive cycles with addr 0x80, 0x81, 0x82; out_ready=1.
  -> three complete records in order, each separated by exactly one out_valid=0 cycle.
